// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the imem program loader.
// Holds the FSM state encoding, the default sync byte and the frame field widths.
package imem_program_loader_pkg;

   typedef enum logic [2:0] {
      LDR_IDLE   = 3'd0,
      LDR_LEN_LO = 3'd1,
      LDR_LEN_HI = 3'd2,
      LDR_DATA   = 3'd3,
      LDR_CSUM   = 3'd4,
      LDR_DONE   = 3'd5,
      LDR_ERR    = 3'd6
   } ldr_state_e;

   localparam int BYTE_W = 8;
   localparam int LEN_W  = 16;
   localparam int ADDR_W = 64;

   localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/imem_program_loader.sv
// Writer side of the instruction memory: parses a framed byte stream (sync, len, payload, xor)
// into imem writes and keeps the core held until a frame loads with a correct checksum.
module imem_program_loader
   import imem_program_loader_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR = 64'd0,
   parameter int                MEM_SIZE  = 1024,
   parameter logic [BYTE_W-1:0] SYNC      = SYNC_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              imem_wEn,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [BYTE_W-1:0] imem_wdata,
   output logic              cpu_run,
   output logic              load_done,
   output logic              load_err
);

   localparam logic [ADDR_W-1:0] MEM_LIMIT = 64'(MEM_SIZE);

   ldr_state_e        r_state, w_state;
   logic [LEN_W-1:0]  r_len, w_len;
   logic [LEN_W-1:0]  r_cnt, w_cnt;
   logic [BYTE_W-1:0] r_csum, w_csum;
   logic              r_in_ready;
   logic              r_wen, w_wen;
   logic [ADDR_W-1:0] r_addr, w_addr;
   logic [BYTE_W-1:0] r_wdata, w_wdata;
   logic              r_run, w_run;
   logic              r_done, w_done;
   logic              r_err, w_err;

   logic              w_acc;
   logic              w_is_sync;
   logic [LEN_W-1:0]  w_len_full;
   logic              w_fits;
   logic              w_last;

   assign w_acc      = in_valid & r_in_ready;
   assign w_is_sync  = (in_data == SYNC);
   assign w_len_full = {in_data, r_len[BYTE_W-1:0]};
   // 64-bit sum so a large length can never wrap past the bound
   assign w_fits     = (BASE_ADDR + {{(ADDR_W-LEN_W){1'b0}}, w_len_full}) <= MEM_LIMIT;
   assign w_last     = (r_cnt == (r_len - 16'd1));

   always_comb begin
      w_state = r_state;
      w_len   = r_len;
      w_cnt   = r_cnt;
      w_csum  = r_csum;
      w_wen   = 1'b0;
      w_addr  = r_addr;
      w_wdata = r_wdata;
      w_run   = r_run;
      w_done  = 1'b0;
      w_err   = r_err;
      if (w_acc) begin
         case (r_state)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
               if (w_is_sync) begin
                  w_state = LDR_LEN_LO;
                  w_csum  = '0;
                  w_err   = 1'b0;
                  w_run   = 1'b0;
               end
            end
            LDR_LEN_LO: begin
               w_len   = {{(LEN_W-BYTE_W){1'b0}}, in_data};
               w_state = LDR_LEN_HI;
            end
            LDR_LEN_HI: begin
               w_len = w_len_full;
               w_cnt = '0;
               if (!w_fits) begin
                  w_state = LDR_ERR;
                  w_err   = 1'b1;
                  w_run   = 1'b0;
               end else if (w_len_full == '0) begin
                  w_state = LDR_CSUM;
               end else begin
                  w_state = LDR_DATA;
               end
            end
            LDR_DATA: begin
               w_wen   = 1'b1;
               w_addr  = BASE_ADDR + {{(ADDR_W-LEN_W){1'b0}}, r_cnt};
               w_wdata = in_data;
               w_csum  = r_csum ^ in_data;
               w_cnt   = r_cnt + 16'd1;
               if (w_last) w_state = LDR_CSUM;
            end
            LDR_CSUM: begin
               if (in_data == r_csum) begin
                  w_state = LDR_DONE;
                  w_done  = 1'b1;
                  w_run   = 1'b1;
               end else begin
                  w_state = LDR_ERR;
                  w_err   = 1'b1;
                  w_run   = 1'b0;
               end
            end
            default: w_state = LDR_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= LDR_IDLE;
         r_len      <= '0;
         r_cnt      <= '0;
         r_csum     <= '0;
         r_in_ready <= 1'b0;
         r_wen      <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_run      <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state    <= w_state;
         r_len      <= w_len;
         r_cnt      <= w_cnt;
         r_csum     <= w_csum;
         r_in_ready <= 1'b1;
         r_wen      <= w_wen;
         r_addr     <= w_addr;
         r_wdata    <= w_wdata;
         r_run      <= w_run;
         r_done     <= w_done;
         r_err      <= w_err;
      end
   end

   assign in_ready   = r_in_ready;
   assign imem_wEn   = r_wen;
   assign imem_addr  = r_addr;
   assign imem_wdata = r_wdata;
   assign cpu_run    = r_run;
   assign load_done  = r_done;
   assign load_err   = r_err;

endmodule
